brick_grid_arbiter: RTL

- Owns the 5x12 brick hit-state array for the breakout game.
- Shares the array between two requesters: the pixel renderer, which reads every cycle while `bright` is high, and the ball-collision engine, which does read-modify-write accesses during blanking.
- Sequences a full-grid clear sweep for a new game.
- Produces the remaining-brick count, the all-cleared flag and a score-increment strobe for the score and game-state logic.

---
 rtl/brick_grid_arbiter_if.sv | 28 ++
 rtl/brick_grid_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/brick_grid_arbiter_if.sv
// rtl/brick_grid_arbiter_if.sv - renderer, collision, clear and status signals of the brick grid arbiter
interface brick_grid_arbiter_if;
  logic       bright;
  logic [2:0] rd_row;
  logic [3:0] rd_col;
  logic       rd_hit;
  logic       rd_valid;
  logic       col_req;
  logic [2:0] col_row;
  logic [3:0] col_col;
  logic       col_ack;
  logic       col_was_hit;
  logic       score_inc;
  logic       clear_req;
  logic       clear_busy;
  logic [5:0] bricks_left;
  logic       all_clear;

  modport master (
    output bright, rd_row, rd_col, col_req, col_row, col_col, clear_req,
    input  rd_hit, rd_valid, col_ack, col_was_hit, score_inc, clear_busy, bricks_left, all_clear
  );

  modport slave (
    input  bright, rd_row, rd_col, col_req, col_row, col_col, clear_req,
    output rd_hit, rd_valid, col_ack, col_was_hit, score_inc, clear_busy, bricks_left, all_clear
  );
endinterface

// File: rtl/brick_grid_arbiter.sv
// rtl/brick_grid_arbiter.sv - brick hit-state array shared between renderer, collision engine and clear sweep
module brick_grid_arbiter #(
  parameter int ROWS  = 5,
  parameter int COLS  = 12,
  parameter int IDX_W = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  brick_grid_arbiter_if.slave  bus
);
  localparam int NB = ROWS * COLS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [5:0]       FULL_CNT = 6'(NB);

  typedef enum logic [1:0] {IDLE, GRANT, ACK, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [NB-1:0]    hit_q, hit_d;
  logic [IDX_W-1:0] clear_idx_q, clear_idx_d;
  logic [5:0]       bricks_left_q, bricks_left_d;
  logic             pend_q, pend_d;
  logic             col_was_hit_q, col_was_hit_d;
  logic             score_inc_q, score_inc_d;
  logic             rd_hit_q, rd_hit_d;
  logic             rd_valid_q, rd_valid_d;

  logic             rd_in_range, col_in_range;
  logic [IDX_W-1:0] rd_idx, col_idx;

  // Flat indices are only meaningful when the row/column pair is in range.
  assign rd_in_range  = (bus.rd_row < 3'(ROWS)) && (bus.rd_col < 4'(COLS));
  assign col_in_range = (bus.col_row < 3'(ROWS)) && (bus.col_col < 4'(COLS));
  assign rd_idx  = IDX_W'(bus.rd_row) * IDX_W'(COLS) + IDX_W'(bus.rd_col);
  assign col_idx = IDX_W'(bus.col_row) * IDX_W'(COLS) + IDX_W'(bus.col_col);

  always_comb begin
    state_d       = state_q;
    hit_d         = hit_q;
    clear_idx_d   = clear_idx_q;
    bricks_left_d = bricks_left_q;
    pend_d        = pend_q;
    col_was_hit_d = col_was_hit_q;
    score_inc_d   = 1'b0;
    rd_valid_d    = bus.bright && (state_q != CLEAR) && (state_q != GRANT);
    rd_hit_d      = rd_hit_q;
    if (rd_valid_d) begin
      rd_hit_d = rd_in_range ? hit_q[rd_idx] : 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.clear_req || pend_q) begin
          state_d     = CLEAR;
          pend_d      = 1'b0;
          clear_idx_d = '0;
        end else if (bus.col_req && !bus.bright) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.clear_req) begin
          pend_d = 1'b1;
        end
        if (col_in_range) begin
          col_was_hit_d  = hit_q[col_idx];
          hit_d[col_idx] = 1'b1;
          if (!hit_q[col_idx] && (bricks_left_q != 6'd0)) begin
            bricks_left_d = bricks_left_q - 6'd1;
            score_inc_d   = 1'b1;
          end
        end else begin
          col_was_hit_d = 1'b1;
        end
        state_d = ACK;
      end
      ACK: begin
        if (bus.clear_req) begin
          pend_d = 1'b1;
        end
        state_d = IDLE;
      end
      CLEAR: begin
        hit_d[clear_idx_q] = 1'b0;
        if (clear_idx_q == LAST_IDX) begin
          bricks_left_d = FULL_CNT;
          state_d       = IDLE;
        end else begin
          clear_idx_d = clear_idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hit_q         <= '0;
      clear_idx_q   <= '0;
      bricks_left_q <= FULL_CNT;
      pend_q        <= 1'b0;
      col_was_hit_q <= 1'b0;
      score_inc_q   <= 1'b0;
      rd_hit_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hit_q         <= hit_d;
      clear_idx_q   <= clear_idx_d;
      bricks_left_q <= bricks_left_d;
      pend_q        <= pend_d;
      col_was_hit_q <= col_was_hit_d;
      score_inc_q   <= score_inc_d;
      rd_hit_q      <= rd_hit_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  assign bus.rd_hit      = rd_hit_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.col_ack     = (state_q == ACK);
  assign bus.col_was_hit = col_was_hit_q;
  assign bus.score_inc   = score_inc_q;
  assign bus.clear_busy  = (state_q == CLEAR);
  assign bus.bricks_left = bricks_left_q;
  assign bus.all_clear   = (bricks_left_q == 6'd0);
endmodule
